// File: rtl/fft_output_serializer.sv
// fft_output_serializer
//
// Parallel-to-serial converter at the back end of the 8-point FFT datapath.
// A start request in idle captures the packed parallel result and streams it
// out one CHUNK_WIDTH slice per clock, least-significant slice first. Each
// emitted slice is flagged valid, and a done pulse accompanies the final one.
//
// Ports:
//   clk                 single clock, rising edge
//   reset_n             synchronous reset, ACTIVE HIGH (1 = reset)
//   start_serialize     capture input_data and begin a transfer (idle only)
//   input_data          parallel vector, sampled on the accepting edge only
//   output_data         current slice, zero-extended to OUTPUT_WIDTH
//   output_valid        output_data holds a valid slice this cycle
//   serialization_done  one-cycle pulse coincident with the last slice
//
// INPUT_WIDTH must be a multiple of CHUNK_WIDTH, and CHUNK_WIDTH must not
// exceed OUTPUT_WIDTH.

module fft_output_serializer #(
  parameter int unsigned INPUT_WIDTH  = 256,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned CHUNK_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_serialize,
  input  logic [INPUT_WIDTH-1:0]  input_data,
  output logic [OUTPUT_WIDTH-1:0] output_data,
  output logic                    output_valid,
  output logic                    serialization_done
);

  localparam int unsigned NumBeats = INPUT_WIDTH / CHUNK_WIDTH;
  // Keep the counter at least one bit wide so N = 1 still elaborates.
  localparam int unsigned CntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]  shift_q, shift_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_serialize) begin
          // Slice 0 goes straight out; the register keeps the pending slices
          // aligned so the next one always sits in the low chunk.
          shift_d                 = input_data >> CHUNK_WIDTH;
          data_d[CHUNK_WIDTH-1:0] = input_data[CHUNK_WIDTH-1:0];
          valid_d                 = 1'b1;
          if (NumBeats == 1) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StShift;
          end
        end
      end
      StShift: begin
        data_d[CHUNK_WIDTH-1:0] = shift_q[CHUNK_WIDTH-1:0];
        shift_d                 = shift_q >> CHUNK_WIDTH;
        valid_d                 = 1'b1;
        if (cnt_q == LastBeat) begin
          // Back in idle on this edge so a start on the next edge streams on
          // without a gap.
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign output_data        = data_q;
  assign output_valid       = valid_q;
  assign serialization_done = done_q;

endmodule

// File: tb/tb_fft_output_serializer.sv
module tb_fft_output_serializer;

  logic         clk;
  logic         reset_n;
  logic         start_serialize;
  logic [255:0] input_data;
  logic [31:0]  output_data;
  logic         output_valid;
  logic         serialization_done;

  fft_output_serializer #(
    .INPUT_WIDTH (256),
    .OUTPUT_WIDTH(32),
    .CHUNK_WIDTH (32)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_serialize   (start_serialize),
    .input_data        (input_data),
    .output_data       (output_data),
    .output_valid      (output_valid),
    .serialization_done(serialization_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } beat_t;

  beat_t exp_q[$];
  int    checks;
  int    failures;

  localparam logic [255:0] PatA = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] PatB = {4{64'hFEDCBA9876543210}};

  // Expected beats for a transfer of d: slice i, LSB first, done on the last.
  task automatic push_transfer(input logic [255:0] d);
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.data = d[i*32 +: 32];
      b.done = (i == 7);
      exp_q.push_back(b);
    end
  endtask

  function automatic beat_t pop_exp();
    beat_t b;
    if (exp_q.size() == 0) begin
      b.data = 'x;
      b.done = 1'bx;
    end else begin
      b = exp_q.pop_front();
    end
    return b;
  endfunction

  // Outputs are sampled on the falling edge, inputs are driven there too.
  task automatic test_reset();
    beat_t e;
    reset_n         = 1'b1;
    start_serialize = 1'b1;
    input_data      = PatA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, serialization_done, output_data} !== 34'd0)
        begin
        failures++;
        $display("FAIL reset_edge%0d: got valid=%b done=%b data=%h, want 0/0/0",
                 i, output_valid, serialization_done, output_data);
      end
    end
    reset_n         = 1'b0;
    start_serialize = 1'b0;
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got valid=%b, want 0", output_valid);
    end
    e = '0;
  endtask

  task automatic test_basic();
    input_data      = PatA;
    start_serialize = 1'b1;
    // Spelled out as literals: low word 89ABCDEF, high word 01234567.
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.data = (i % 2 == 0) ? 32'h89ABCDEF : 32'h01234567;
      b.done = (i == 7);
      exp_q.push_back(b);
    end
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      @(negedge clk);
      start_serialize = 1'b0;
      input_data      = '1;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL basic_beat%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
    end
    @(negedge clk);
    checks++;
    if ({output_valid, serialization_done, output_data} !== 34'd0) begin
      failures++;
      $display("FAIL basic_after: got valid=%b done=%b data=%h, want 0/0/0",
               output_valid, serialization_done, output_data);
    end
  endtask

  task automatic test_second_after_gap();
    repeat (3) @(negedge clk);
    input_data      = PatB;
    start_serialize = 1'b1;
    push_transfer(PatB);
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      @(negedge clk);
      start_serialize = 1'b0;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL second_beat%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
    end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0 || serialization_done !== 1'b0) begin
      failures++;
      $display("FAIL second_after: got valid=%b done=%b, want 0/0",
               output_valid, serialization_done);
    end
  endtask

  task automatic test_ignore_busy();
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    input_data      = d;
    start_serialize = 1'b1;
    push_transfer(d);
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      @(negedge clk);
      // Second start with different data lands while beat 4 is on the bus.
      start_serialize = (i == 3);
      input_data      = ~d;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL busy_beat%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
    end
    start_serialize = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, serialization_done} !== 2'b00) begin
        failures++;
        $display("FAIL busy_no_extra%0d: got valid=%b done=%b, want 0/0",
                 i, output_valid, serialization_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    input_data      = PatA;
    start_serialize = 1'b1;
    push_transfer(PatA);
    for (int i = 0; i < 16; i++) begin
      beat_t e;
      @(negedge clk);
      start_serialize = 1'b0;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL b2b_beat%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
      if (i == 7) begin
        input_data      = PatB;
        start_serialize = 1'b1;
        push_transfer(PatB);
      end else begin
        input_data = '0;
      end
    end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after: got valid=%b, want 0", output_valid);
    end
  endtask

  task automatic test_reset_mid_transfer();
    input_data      = PatB;
    start_serialize = 1'b1;
    push_transfer(PatB);
    for (int i = 0; i < 3; i++) begin
      beat_t e;
      @(negedge clk);
      start_serialize = 1'b0;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL midrst_beat%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
    end
    reset_n         = 1'b1;
    start_serialize = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset_n         = 1'b0;
    start_serialize = 1'b0;
    checks++;
    if ({output_valid, serialization_done, output_data} !== 34'd0) begin
      failures++;
      $display("FAIL midrst_zero: got valid=%b done=%b data=%h, want 0/0/0",
               output_valid, serialization_done, output_data);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, serialization_done} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_quiet%0d: got valid=%b done=%b, want 0/0",
                 i, output_valid, serialization_done);
      end
    end
    input_data      = PatA;
    start_serialize = 1'b1;
    push_transfer(PatA);
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      @(negedge clk);
      start_serialize = 1'b0;
      e = pop_exp();
      checks++;
      if ({output_valid, output_data, serialization_done} !== {1'b1, e.data, e.done}) begin
        failures++;
        $display("FAIL midrst_again%0d: got valid=%b data=%h done=%b, want 1 %h %b",
                 i, output_valid, output_data, serialization_done, e.data, e.done);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    failures        = 0;
    reset_n         = 1'b1;
    start_serialize = 1'b1;
    input_data      = '0;
    test_reset();
    test_basic();
    test_second_after_gap();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_transfer();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover beats, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_output_serializer.md
# fft_output_serializer

Parallel-to-serial converter at the back end of the 8-point FFT datapath. On a start request it captures a wide parallel vector (the packed FFT result, 8 × 32 bits by default) and emits it one fixed-width slice per clock, least-significant slice first. It flags each emitted slice as valid and pulses a done flag alongside the final slice.

## Interface
- INPUT_WIDTH, 256: width of the parallel input vector.
- OUTPUT_WIDTH, 32: width of the output_data port.
- CHUNK_WIDTH, 32: bits taken from the input per output beat.
  - INPUT_WIDTH must be an exact multiple of CHUNK_WIDTH.
  - CHUNK_WIDTH must not exceed OUTPUT_WIDTH.
  - N = INPUT_WIDTH/CHUNK_WIDTH beats; default N = 8.
- clk  in  1: single clock; all logic on its rising edge.
- reset_n  in  1: synchronous, active-high reset. The port keeps the codebase name, but 1 = reset, sampled only on the rising clk edge.
- start_serialize  in  1: request to capture input_data and begin a transfer.
- input_data  in  INPUT_WIDTH: parallel data, sampled only on the accepting edge.
- output_data  out  OUTPUT_WIDTH: current slice, zero-extended from CHUNK_WIDTH.
- output_valid  out  1: output_data carries a valid slice this cycle.
- serialization_done  out  1: one-cycle pulse coincident with the last slice.

## Operation
- States: IDLE and SHIFT. A beat counter of ceil(log2(N)) bits indexes the current slice.
- In IDLE with start_serialize = 1 at an edge:
  - input_data is copied into an internal shift register.
  - output_data is loaded with slice 0 (input_data[CHUNK_WIDTH-1:0]) and output_valid is set.
  - The counter is set to 1 and the FSM enters SHIFT. If N = 1, done is set and the FSM stays in IDLE.
- In SHIFT, each edge emits slice i = input[(i+1)·CHUNK_WIDTH-1 : i·CHUNK_WIDTH] with output_valid = 1 and increments the counter.
- When slice N-1 is emitted:
  - serialization_done = 1 for that cycle.
  - The FSM returns to IDLE on that same edge.
- In IDLE with no start: output_valid = 0, serialization_done = 0, output_data = 0.
- start_serialize is ignored while in SHIFT. It is neither queued nor does it restart the transfer.
- input_data changes after capture do not affect the transfer in progress.
- Slice ordering is always LSB-first. Unused upper output bits (OUTPUT_WIDTH > CHUNK_WIDTH) are 0.

## Timing
- Reset (reset_n = 1 at an edge), including mid-transfer, forces all of the following on that edge, regardless of start_serialize:
  - state = IDLE, counter = 0, shift register = 0;
  - output_data = 0, output_valid = 0, serialization_done = 0.
- Start accepted at edge k:
  - Slice i is visible after edge k+i, for i = 0..N-1.
  - output_valid is high for exactly N consecutive cycles.
  - serialization_done is high only after edge k+N-1.
- Latency: first slice appears one edge after start is sampled.
- Back-to-back transfers: start high at edge k+N is accepted. The next stream begins immediately with no idle gap, and valid stays high.
- Start held high continuously produces repeated transfers every N cycles. Each transfer re-samples input_data at its accepting edge.
- Start asserted during edges k+1..k+N-1 has no effect.

## Test plan
- Reset: hold reset_n = 1 for 2 edges with start_serialize = 1 → output_valid = 0, serialization_done = 0, output_data = 0.
- Basic transfer: input 256'h0123456789ABCDEF repeated 4×, start pulsed for one edge → 8 valid beats alternating 89ABCDEF, 01234567. done = 1 only on beat 8, then valid = 0.
- Second transfer after idle gap: input 256'hFEDCBA9876543210 repeated 4× → beats alternate 76543210, FEDCBA98 for 8 cycles, done on beat 8.
- Ignore start while busy: pulse start again at beat 4 with a different input → the original 8 beats complete unchanged and no extra beats follow.
- Back-to-back: start high at edge k and again at edge k+8 with new data → 16 consecutive valid beats, done pulses on beats 8 and 16.
- Reset mid-transfer: assert reset_n = 1 at beat 3 → outputs zero on the next edge. No done pulse occurs, and a subsequent start transfers all 8 beats correctly.
